// File: rtl/coin_pulse_gen.sv
// Coin input conditioner: debounces raw coin inputs, queues credits and replays them as
// fixed-width pulses with a guaranteed gap. Define COIN_TOTAL_EN to add the coin_total counter.
module coin_pulse_gen #(
  parameter int NCOIN       = 2,
  parameter int DB_TICKS    = 30720,
  parameter int PULSE_TICKS = 614400,
  parameter int GAP_TICKS   = 614400,
  parameter int QMAX        = 7,
  parameter int QW          = $clog2(QMAX + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENA_6,
  input  logic             clr,
  input  logic             lock,
  input  logic [NCOIN-1:0] coin_in,
  output logic             coin_out,
  output logic [QW-1:0]    pending,
  output logic             busy
`ifdef COIN_TOTAL_EN
  ,
  output logic [15:0]      coin_total
`endif
);

  localparam int DBW  = $clog2(DB_TICKS + 1);
  localparam int TMAX = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CW   = $clog2(NCOIN + 1);
  localparam int SW   = QW + CW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [TW-1:0]    timer, timer_next;
  logic [QW-1:0]    pending_next;
  logic             start;
  logic [NCOIN-1:0] sync1, sync2, stable, stable_d, events;
  logic [DBW-1:0]   db_cnt [NCOIN];
  logic [CW-1:0]    ev_cnt;
  logic [SW-1:0]    sum;

  // Two-flop synchroniser and edge-detect history of the debounced levels
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1    <= '0;
      sync2    <= '0;
      stable_d <= '0;
    end else begin
      sync1    <= coin_in;
      sync2    <= sync1;
      stable_d <= stable;
    end
  end

  // Per-input debounce: a new level must persist for DB_TICKS enable ticks
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stable <= '0;
      for (int i = 0; i < NCOIN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCOIN; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (ENA_6) begin
          if (db_cnt[i] == DBW'(DB_TICKS - 1)) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign events = stable & ~stable_d;

  // Count simultaneous credit events and compute the saturating queue update
  always_comb begin
    ev_cnt = '0;
    for (int i = 0; i < NCOIN; i++) ev_cnt = ev_cnt + CW'(events[i]);
    sum = SW'(pending) + SW'(ev_cnt) - SW'(start);
    if (clr) begin
      pending_next = '0;
    end else if (sum > SW'(QMAX)) begin
      pending_next = QW'(QMAX);
    end else begin
      pending_next = sum[QW-1:0];
    end
  end

  // Pulse FSM next-state; lock is only honoured before a pulse begins
  always_comb begin
    state_next = state;
    timer_next = timer;
    start      = 1'b0;
    case (state)
      S_IDLE: begin
        if ((pending != '0) && !lock && !clr) begin
          state_next = S_PULSE;
          timer_next = '0;
          start      = 1'b1;
        end else begin
          timer_next = '0;
        end
      end
      S_PULSE: begin
        if (ENA_6) begin
          if (timer == TW'(PULSE_TICKS - 1)) begin
            state_next = S_GAP;
            timer_next = '0;
          end else begin
            timer_next = timer + 1'b1;
          end
        end else begin
          timer_next = timer;
        end
      end
      S_GAP: begin
        if (ENA_6) begin
          if (timer == TW'(GAP_TICKS - 1)) begin
            state_next = S_IDLE;
            timer_next = '0;
          end else begin
            timer_next = timer + 1'b1;
          end
        end else begin
          timer_next = timer;
        end
      end
      default: begin
        state_next = S_IDLE;
        timer_next = '0;
      end
    endcase
  end

  // State, queue and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      timer    <= '0;
      pending  <= '0;
      coin_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      pending  <= pending_next;
      coin_out <= (state_next == S_PULSE);
      busy     <= (state_next != S_IDLE);
    end
  end

`ifdef COIN_TOTAL_EN
  // Lifetime pulse counter, untouched by clr
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      coin_total <= 16'd0;
    end else if (start) begin
      coin_total <= coin_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Self-checking bench for coin_pulse_gen: vector table of press scenarios plus hand sequences,
// with a pulse scoreboard that checks width, enable-tick count and gap of every coin pulse.
module tb_coin_pulse_gen;

  localparam int NCOIN = 2;
  localparam int DB    = 4;
  localparam int PULSE = 8;
  localparam int GAP   = 6;
  localparam int QMAX  = 3;
  localparam int QW    = $clog2(QMAX + 1);

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             ENA_6;
  logic             clr = 1'b0;
  logic             lock = 1'b0;
  logic [NCOIN-1:0] coin_in = '0;
  logic             coin_out;
  logic [QW-1:0]    pending;
  logic             busy;
`ifdef COIN_TOTAL_EN
  logic [15:0]      coin_total;
`endif

  logic [1:0] ena_cnt = 2'd0;
  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int peak = 0;
  int cur_vec = 0;
  int exp_q[$];

  coin_pulse_gen #(
    .NCOIN(NCOIN), .DB_TICKS(DB), .PULSE_TICKS(PULSE), .GAP_TICKS(GAP), .QMAX(QMAX)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENA_6(ENA_6), .clr(clr), .lock(lock), .coin_in(coin_in),
    .coin_out(coin_out), .pending(pending), .busy(busy)
`ifdef COIN_TOTAL_EN
    , .coin_total(coin_total)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) ena_cnt <= ena_cnt + 2'd1;
  assign ENA_6 = (ena_cnt == 2'd3);

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse monitor / scoreboard
  int  cyc = 0, rise_cyc = 0, fall_cyc = 0, ena_hi = 0;
  bit  prev = 1'b0, have_fall = 1'b0;
  always @(negedge CLK) begin
    if (RESET) begin
      prev = 1'b0;
      have_fall = 1'b0;
    end else begin
      if (int'(pending) > peak) peak = int'(pending);
      if (coin_out && !prev) begin
        rise_cyc = cyc;
        ena_hi = 0;
        pulses++;
        if (have_fall) check(cyc - fall_cyc >= 4 * GAP, "gap_len", cyc - fall_cyc, 4 * GAP);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_pulse", cur_vec, -1);
        end else begin
          int v;
          v = exp_q.pop_front();
          check(v == cur_vec, "pulse_owner", cur_vec, v);
        end
      end
      if (coin_out && ENA_6) ena_hi++;
      if (!coin_out && prev) begin
        check((cyc - rise_cyc >= 4 * PULSE - 3) && (cyc - rise_cyc <= 4 * PULSE),
              "pulse_width", cyc - rise_cyc, 4 * PULSE);
        check(ena_hi == PULSE, "pulse_ticks", ena_hi, PULSE);
        fall_cyc = cyc;
        have_fall = 1'b1;
      end
      prev = coin_out;
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [1:0] pat);
    coin_in = pat;
    tick(20);
    coin_in = '0;
    tick(20);
  endtask

  task automatic wait_coin(input int budget);
    int n = 0;
    while (!coin_out && n < budget) begin
      tick(1);
      n++;
    end
    check(coin_out == 1'b1, "coin_start_timeout", n, budget);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 40 && n < budget) begin
      tick(1);
      n++;
      if (!busy && pending == '0 && !coin_out) quiet++;
      else quiet = 0;
    end
    check(quiet >= 40, "idle_timeout", n, budget);
  endtask

  typedef struct {
    logic [1:0] pat;
    int         n;
    bit         lk;
    int         exp_pulses;
    int         exp_peak;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int p0;
    vecs[0] = '{pat: 2'b01, n: 1, lk: 1'b0, exp_pulses: 1, exp_peak: 1};
    vecs[1] = '{pat: 2'b10, n: 1, lk: 1'b0, exp_pulses: 1, exp_peak: 1};
    vecs[2] = '{pat: 2'b11, n: 1, lk: 1'b0, exp_pulses: 2, exp_peak: 2};
    vecs[3] = '{pat: 2'b01, n: 2, lk: 1'b1, exp_pulses: 2, exp_peak: 2};
    vecs[4] = '{pat: 2'b10, n: 5, lk: 1'b1, exp_pulses: 3, exp_peak: 3};
    vecs[5] = '{pat: 2'b01, n: 2, lk: 1'b0, exp_pulses: 2, exp_peak: 1};

    tick(3);
    RESET = 1'b0;
    tick(1);
    check(coin_out == 1'b0, "rst_coin_out", coin_out, 0);
    check(pending == '0, "rst_pending", pending, 0);
    check(busy == 1'b0, "rst_busy", busy, 0);
`ifdef COIN_TOTAL_EN
    check(coin_total == 16'd0, "rst_total", coin_total, 0);
`endif

    for (int k = 0; k < 6; k++) begin
      cur_vec = k;
      peak = 0;
      p0 = pulses;
      lock = vecs[k].lk;
      for (int j = 0; j < vecs[k].exp_pulses; j++) exp_q.push_back(k);
      for (int j = 0; j < vecs[k].n; j++) press(vecs[k].pat);
      if (vecs[k].lk) begin
        check(pulses == p0, "lock_no_pulse", pulses - p0, 0);
        check(int'(pending) == vecs[k].exp_peak, "lock_pending", pending, vecs[k].exp_peak);
        lock = 1'b0;
      end
      wait_idle(2000);
      check(pulses - p0 == vecs[k].exp_pulses, "vec_pulses", pulses - p0, vecs[k].exp_pulses);
      check(peak == vecs[k].exp_peak, "vec_peak", peak, vecs[k].exp_peak);
      check(exp_q.size() == 0, "vec_missing", exp_q.size(), 0);
    end

    // Bounce: 8-CLK toggles never survive debounce
    cur_vec = 100;
    p0 = pulses;
    for (int j = 0; j < 8; j++) begin
      coin_in[0] = ~coin_in[0];
      tick(8);
    end
    coin_in = '0;
    tick(60);
    check(pulses == p0, "bounce_pulses", pulses - p0, 0);
    check(pending == '0, "bounce_pending", pending, 0);

    // Burst: first pulse running, then locked presses saturate the queue
    cur_vec = 101;
    p0 = pulses;
    for (int j = 0; j < 4; j++) exp_q.push_back(101);
    coin_in = 2'b01;
    wait_coin(80);
    lock = 1'b1;
    tick(10);
    coin_in = '0;
    tick(20);
    for (int j = 0; j < 4; j++) press(2'b01);
    check(int'(pending) == QMAX, "burst_sat", pending, QMAX);
    check(pulses - p0 == 1, "burst_first", pulses - p0, 1);
    lock = 1'b0;
    wait_idle(2000);
    check(pulses - p0 == 4, "burst_pulses", pulses - p0, 4);

    // Simultaneous: two events, one starts immediately
    cur_vec = 102;
    p0 = pulses;
    for (int j = 0; j < 2; j++) exp_q.push_back(102);
    coin_in = 2'b11;
    wait_coin(80);
    check(int'(pending) == 1, "simul_pending", pending, 1);
    coin_in = '0;
    wait_idle(2000);
    check(pulses - p0 == 2, "simul_pulses", pulses - p0, 2);

    // clr mid-pulse flushes the queue but the pulse completes
    cur_vec = 103;
    p0 = pulses;
    exp_q.push_back(103);
    lock = 1'b1;
    press(2'b01);
    press(2'b01);
    check(pending == 2'd2, "clr_pre_pending", pending, 2);
    lock = 1'b0;
    wait_coin(20);
    tick(10);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check(pending == '0, "clr_pending", pending, 0);
    check(coin_out == 1'b1, "clr_pulse_alive", coin_out, 1);
    wait_idle(2000);
    check(pulses - p0 == 1, "clr_pulses", pulses - p0, 1);
`ifdef COIN_TOTAL_EN
    check(int'(coin_total) == pulses, "total_count", coin_total, pulses);
`endif

    // Reset mid-pulse clears everything asynchronously
    cur_vec = 104;
    exp_q.push_back(104);
    lock = 1'b1;
    press(2'b01);
    press(2'b01);
    lock = 1'b0;
    wait_coin(20);
    tick(10);
    #2 RESET = 1'b1;
    #1;
    check(coin_out == 1'b0, "rstmid_coin_out", coin_out, 0);
    check(pending == '0, "rstmid_pending", pending, 0);
    check(busy == 1'b0, "rstmid_busy", busy, 0);
`ifdef COIN_TOTAL_EN
    check(coin_total == 16'd0, "rstmid_total", coin_total, 0);
`endif
    tick(3);
    RESET = 1'b0;
    tick(20);
    check(coin_out == 1'b0, "post_rst_quiet", coin_out, 0);
    check(exp_q.size() == 0, "final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
